// File: rtl/aes_inv_pkg.sv
// Shared types and GF(2^8) helpers for the InvMixColumns engine.
// Optional macro INV_MIX_FWD_EN (used by the engine files) adds a forward
// MixColumns mode; nothing in this package depends on it.
package aes_inv_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // First row of the inverse matrix; later rows are right-rotations of it.
  localparam byte_t INV_C0 = 8'h0e;
  localparam byte_t INV_C1 = 8'h0b;
  localparam byte_t INV_C2 = 8'h0d;
  localparam byte_t INV_C3 = 8'h09;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a constant as a sum of xtime powers; with a constant c this
  // reduces to the usual x9/xb/xd/xe XOR networks.
  function automatic byte_t gf_mul_const(input byte_t b, input byte_t c);
    byte_t acc;
    byte_t p;
    acc = '0;
    p   = b;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic byte_t inv_coef(input logic [1:0] k);
    case (k)
      2'd0:    return INV_C0;
      2'd1:    return INV_C1;
      2'd2:    return INV_C2;
      default: return INV_C3;
    endcase
  endfunction

endpackage

// File: rtl/inv_mix_col.sv
// Combinational single-column InvMixColumns (row 0 in bits [31:24]).
// With INV_MIX_FWD_EN defined, fwd_i=1 selects the forward MixColumns matrix.
module inv_mix_col
  import aes_inv_pkg::*;
(
`ifdef INV_MIX_FWD_EN
  input  logic        fwd_i,
`endif
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

`ifdef INV_MIX_FWD_EN
  function automatic byte_t fwd_coef(input logic [1:0] k);
    case (k)
      2'd0:    return 8'h02;
      2'd1:    return 8'h03;
      default: return 8'h01;
    endcase
  endfunction
`endif

  // Row r uses coefficient index (j - r) mod 4 for input byte j.
  always_comb begin
    byte_t      acc;
    byte_t      coef;
    logic [1:0] k;
    col_o = '0;
    acc   = '0;
    coef  = '0;
    k     = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        k = 2'(j - r);
`ifdef INV_MIX_FWD_EN
        coef = fwd_i ? fwd_coef(k) : inv_coef(k);
`else
        coef = inv_coef(k);
`endif
        acc = acc ^ gf_mul_const(col_i[31-8*j -: 8], coef);
      end
      col_o[31-8*r -: 8] = acc;
    end
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns engine with valid/ready on both sides.
// COLS_PER_CYCLE columns are transformed per clock (1, 2 or 4).
// Optional macro INV_MIX_FWD_EN adds port fwd, latched on accept, that
// switches the whole block to forward MixColumns.
module inv_mix_columns_seq
  import aes_inv_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef INV_MIX_FWD_EN
  input  logic         fwd,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int         NSTEP     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(NSTEP - 1);
  localparam logic [1:0] CPC_W     = 2'(COLS_PER_CYCLE);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] cols_q [4];
  logic [31:0] cols_d [4];
  logic        accept;
`ifdef INV_MIX_FWD_EN
  logic        fwd_q, fwd_d;
`endif

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  // Step cnt covers columns cnt*COLS_PER_CYCLE + k; for 4 columns cnt stays 0.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    localparam logic [1:0] K_W = 2'(k);
    assign col_idx[k] = cnt_q * CPC_W + K_W;
    assign col_in[k]  = cols_q[col_idx[k]];
    inv_mix_col u_col (
`ifdef INV_MIX_FWD_EN
      .fwd_i (fwd_q),
`endif
      .col_i (col_in[k]),
      .col_o (col_out[k])
    );
  end

  // Ready in IDLE, and in DONE only when the result is being taken this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    in_ready = 1'b1;
        DONE:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  // Next-state, counter and working-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cols_d  = cols_q;
`ifdef INV_MIX_FWD_EN
    fwd_d   = fwd_q;
`endif
    case (state_q)
      IDLE: ;
      CALC: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          cols_d[col_idx[k]] = col_out[k];
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      for (int c = 0; c < 4; c++) begin
        cols_d[c] = in_data[127-32*c -: 32];
      end
      cnt_d   = '0;
      state_d = CALC;
`ifdef INV_MIX_FWD_EN
      fwd_d   = fwd;
`endif
    end
  end

  // State and datapath registers; reset drops any in-flight block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cols_q  <= '{default: '0};
`ifdef INV_MIX_FWD_EN
      fwd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cols_q  <= cols_d;
`ifdef INV_MIX_FWD_EN
      fwd_q   <= fwd_d;
`endif
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);

  // Result is only visible while out_valid is high.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int c = 0; c < 4; c++) begin
        out_data[127-32*c -: 32] = cols_q[c];
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2 and 4 columns per
// cycle) checked against a GF(2^8) matrix-multiply reference model.
// Round-trip checks are included when INV_MIX_FWD_EN is defined.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [3];
  logic         out_ready [3];
  logic [127:0] in_data   [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [127:0] out_data  [3];
`ifdef INV_MIX_FWD_EN
  logic         fwd_s     [3];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
`ifdef INV_MIX_FWD_EN
    .fwd(fwd_s[0]),
`endif
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]));

  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
`ifdef INV_MIX_FWD_EN
    .fwd(fwd_s[1]),
`endif
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]));

  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
`ifdef INV_MIX_FWD_EN
    .fwd(fwd_s[2]),
`endif
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x;
    logic [7:0] p;
    x = {1'b0, a};
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit fwd);
    logic [7:0]   m [4][4];
    logic [127:0] res;
    logic [7:0]   acc;
    if (fwd)
      m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
            '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    else
      m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
            '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(s[127-32*c-8*j -: 8], m[r][j]);
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic int nstep(input int k);
    return 4 >> k;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic start_block(input int k, input logic [127:0] data);
    int w;
    w = 0;
    in_data[k]  = data;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("accept_ready_dut%0d", k), in_ready[k], 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  // Counts clock edges from the accept edge until out_valid is seen.
  task automatic wait_result(input int k, output logic [127:0] data, output int lat);
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    data = out_data[k];
  endtask

  task automatic take_result(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  task automatic run_check(input int k, input logic [127:0] data, input logic [127:0] exp,
                           input string tag);
    logic [127:0] got;
    int           lat;
    start_block(k, data);
    wait_result(k, got, lat);
    chk($sformatf("%s_data_dut%0d", tag, k), got, exp);
    chk($sformatf("%s_lat_dut%0d", tag, k), 128'(lat), 128'(nstep(k)));
    take_result(k);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r;
    logic [127:0] d;
    logic [127:0] a;
    int           lat;

    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k]   = '0;
`ifdef INV_MIX_FWD_EN
      fwd_s[k]     = 1'b0;
`endif
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready_dut%0d", k), in_ready[k], 1'b0);
      chk($sformatf("rst_out_valid_dut%0d", k), out_valid[k], 1'b0);
      chk($sformatf("rst_busy_dut%0d", k), busy[k], 1'b0);
      chk($sformatf("rst_out_data_dut%0d", k), out_data[k], '0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("post_rst_in_ready_dut%0d", k), in_ready[k], 1'b1);

    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("idle_out_valid_dut%0d", k), out_valid[k], 1'b0);
        chk($sformatf("idle_busy_dut%0d", k), busy[k], 1'b0);
        chk($sformatf("idle_in_ready_dut%0d", k), in_ready[k], 1'b1);
      end
    end

    for (int k = 0; k < 3; k++) begin
      run_check(k, 128'h8e4da1bc_00000000_00000000_00000000,
                   128'hdb135345_00000000_00000000_00000000, "single_col");
      run_check(k, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8,
                   128'hdb135345_f20a225c_01010101_2d26314c, "full_state");
      run_check(k, 128'hc6c6c6c6_d5d5d7d6_00000000_01010101,
                   128'hc6c6c6c6_d4d4d4d5_00000000_01010101, "c6_d5");
    end

    // Backpressure, then a simultaneous take-and-accept on the DONE edge.
    a = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    start_block(0, a);
    wait_result(0, d, lat);
    chk("bp_first_data", d, 128'hdb135345_f20a225c_01010101_2d26314c);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_data", out_data[0], d);
      chk("bp_hold_in_ready", in_ready[0], 1'b0);
      chk("bp_hold_out_valid", out_valid[0], 1'b1);
    end
    r = 128'hc6c6c6c6_d5d5d7d6_00000000_01010101;
    in_data[0]   = r;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    chk("bp_done_in_ready", in_ready[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    chk("bp_direct_calc_busy", busy[0], 1'b1);
    chk("bp_direct_calc_out_valid", out_valid[0], 1'b0);
    wait_result(0, d, lat);
    chk("bp_second_data", d, 128'hc6c6c6c6_d4d4d4d5_00000000_01010101);
    chk("bp_second_lat", 128'(lat), 128'd4);
    take_result(0);

    // Abort a block after two compute edges.
    start_block(0, a);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", out_valid[0], 1'b0);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_out_data", out_data[0], '0);
    rst = 1'b0;
    @(negedge clk);
    run_check(0, a, 128'hdb135345_f20a225c_01010101_2d26314c, "after_abort");

    for (int k = 0; k < 3; k++) begin
      repeat (10) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        run_check(k, r, ref_mix(r, 1'b0), "random");
      end
    end

`ifdef INV_MIX_FWD_EN
    for (int k = 0; k < 3; k++) begin
      fwd_s[k] = 1'b1;
      run_check(k, 128'hdb135345_00000000_00000000_00000000,
                   128'h8e4da1bc_00000000_00000000_00000000, "fwd_vec");
      fwd_s[k] = 1'b0;
      run_check(k, 128'h8e4da1bc_00000000_00000000_00000000,
                   128'hdb135345_00000000_00000000_00000000, "inv_vec");
      repeat (5) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        fwd_s[k] = 1'b1;
        start_block(k, r);
        fwd_s[k] = 1'b0;
        wait_result(k, d, lat);
        chk($sformatf("rt_fwd_dut%0d", k), d, ref_mix(r, 1'b1));
        take_result(k);
        run_check(k, d, r, "rt_back");
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
